// File: rtl/rpsc_pkg.sv
// Shared types and timing constants for the RPSC power-supply card sequencers.
package rpsc_pkg;

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OK     = 2'd2,
    ST_TRIP   = 2'd3
  } rpsc_state_e;

  localparam int unsigned CLK_PERIOD_NS = 1280;
  localparam int unsigned TICKS_2S      = 1562500;
  localparam int unsigned TICKS_4S      = 3125000;

endpackage

// File: rtl/rpsc_fault_filter.sv
// Per-channel fault debounce: a fault is accepted after FILT_TICKS consecutive
// high samples; any low sample drops it immediately.
module rpsc_fault_filter #(
  parameter int unsigned FILT_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic fault_in,
  output logic filt
);

  localparam int unsigned CW = $clog2(FILT_TICKS + 1);
  localparam logic [CW-1:0] FILT_MAX = CW'(FILT_TICKS);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  always_comb begin
    cnt_nx = '0;
    if (fault_in) begin
      cnt_nx = (cnt == FILT_MAX) ? FILT_MAX : cnt + CW'(1);
    end
  end

  // filt is registered from the next count so it rises on the same edge the count saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      filt <= (cnt_nx == FILT_MAX);
    end
  end

endmodule

// File: rtl/rpsc_interlock_seq.sv
// Interlock and permissive sequencer for one RPSC supply stage: debounced,
// maskable, optionally latching faults with first-fault capture and a settle timer.
module rpsc_interlock_seq
  import rpsc_pkg::*;
#(
  parameter int unsigned N_FAULT      = 7,
  parameter int unsigned OK_TICKS     = 1562500,
  parameter int unsigned FILT_TICKS   = 4,
  parameter int unsigned LATCH_FAULTS = 1,
  localparam int unsigned FW = (N_FAULT > 1) ? $clog2(N_FAULT) : 1,
  localparam int unsigned TW = $clog2(OK_TICKS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_FAULT-1:0] fault_in,
  input  logic [N_FAULT-1:0] fault_mask,
  input  logic               upstream_ok,
  input  logic               ps_act,
  input  logic               u_low,
  input  logic               ack,
  output logic [1:0]         state,
  output logic               not_alarm,
  output logic               on_perm,
  output logic               ps_ok,
  output logic               not_u_low,
  output logic [N_FAULT-1:0] fault_latched,
  output logic [FW-1:0]      first_fault,
  output logic [TW-1:0]      settle_cnt
);

  localparam logic [TW-1:0] OK_MAX = TW'(OK_TICKS);

  rpsc_state_e        state_q;
  rpsc_state_e        state_nx;
  logic [N_FAULT-1:0] filt;
  logic [N_FAULT-1:0] set_v;
  logic [N_FAULT-1:0] latched_nx;
  logic [FW-1:0]      ff_enc;
  logic [FW-1:0]      ff_nx;
  logic [TW-1:0]      cnt_nx;
  logic               trip_nx;
  logic               run_ok;

  for (genvar g = 0; g < N_FAULT; g++) begin : g_filt
    rpsc_fault_filter #(
      .FILT_TICKS (FILT_TICKS)
    ) u_filt (
      .clk      (clk),
      .reset    (reset),
      .fault_in (fault_in[g]),
      .filt     (filt[g])
    );
  end

  assign set_v  = filt & ~fault_mask;
  assign run_ok = upstream_ok & ps_act;

  // Ack clears only bits whose set condition is gone, so set wins over ack
  always_comb begin
    latched_nx = fault_latched | set_v;
    if ((LATCH_FAULTS == 0) || ack) begin
      latched_nx = set_v;
    end
  end

  assign trip_nx = |latched_nx;

  // Lowest-index latched channel
  always_comb begin
    ff_enc = '0;
    for (int i = N_FAULT - 1; i >= 0; i--) begin
      if (latched_nx[i]) begin
        ff_enc = FW'(i);
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    cnt_nx   = settle_cnt;
    ff_nx    = first_fault;
    case (state_q)
      ST_READY: begin
        if (run_ok) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end
      end
      ST_SETTLE: begin
        if (!run_ok) begin
          state_nx = ST_READY;
          cnt_nx   = '0;
        end else if (settle_cnt + TW'(1) == OK_MAX) begin
          state_nx = ST_OK;
          cnt_nx   = OK_MAX;
        end else begin
          cnt_nx = settle_cnt + TW'(1);
        end
      end
      ST_OK: begin
        if (!run_ok) begin
          state_nx = ST_READY;
        end
      end
      ST_TRIP: begin
        state_nx = ST_READY;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_READY;
        cnt_nx   = '0;
      end
    endcase
    // A pending fault overrides every other transition; the culprit is captured only on entry
    if (trip_nx) begin
      state_nx = ST_TRIP;
      cnt_nx   = '0;
      if (state_q != ST_TRIP) begin
        ff_nx = ff_enc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_READY;
      settle_cnt    <= '0;
      fault_latched <= '0;
      first_fault   <= '0;
      not_alarm     <= 1'b1;
      on_perm       <= 1'b1;
      ps_ok         <= 1'b0;
    end else begin
      state_q       <= state_nx;
      settle_cnt    <= cnt_nx;
      fault_latched <= latched_nx;
      first_fault   <= ff_nx;
      not_alarm     <= ~trip_nx;
      on_perm       <= (state_nx != ST_TRIP);
      ps_ok         <= (state_nx == ST_OK);
    end
  end

  assign state     = state_q;
  assign not_u_low = ~(ps_ok & u_low);

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Scoreboard bench for rpsc_interlock_seq: a latching instance and a
// non-latching instance driven from a shared clock and reset.
module tb_rpsc_interlock_seq;
  import rpsc_pkg::*;

  localparam int unsigned NF = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] fault_in, fault_mask;
  logic          upstream_ok, ps_act, u_low, ack;
  logic [1:0]    state;
  logic          not_alarm, on_perm, ps_ok, not_u_low;
  logic [NF-1:0] fault_latched;
  logic [1:0]    first_fault;
  logic [3:0]    settle_cnt;

  logic [NF-1:0] nl_fault_in, nl_mask;
  logic          nl_up, nl_ps, nl_u_low, nl_ack;
  logic [1:0]    nl_state;
  logic          nl_not_alarm, nl_on_perm, nl_ps_ok, nl_not_u_low;
  logic [NF-1:0] nl_latched;
  logic [1:0]    nl_first;
  logic [3:0]    nl_cnt;

  typedef struct {
    logic [1:0]    st;
    logic [NF-1:0] fl;
    int            ff;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rpsc_interlock_seq #(
    .N_FAULT(NF), .OK_TICKS(8), .FILT_TICKS(3), .LATCH_FAULTS(1)
  ) dut (
    .clk(clk), .reset(reset), .fault_in(fault_in), .fault_mask(fault_mask),
    .upstream_ok(upstream_ok), .ps_act(ps_act), .u_low(u_low), .ack(ack),
    .state(state), .not_alarm(not_alarm), .on_perm(on_perm), .ps_ok(ps_ok),
    .not_u_low(not_u_low), .fault_latched(fault_latched),
    .first_fault(first_fault), .settle_cnt(settle_cnt)
  );

  rpsc_interlock_seq #(
    .N_FAULT(NF), .OK_TICKS(8), .FILT_TICKS(3), .LATCH_FAULTS(0)
  ) dut_nl (
    .clk(clk), .reset(reset), .fault_in(nl_fault_in), .fault_mask(nl_mask),
    .upstream_ok(nl_up), .ps_act(nl_ps), .u_low(nl_u_low), .ack(nl_ack),
    .state(nl_state), .not_alarm(nl_not_alarm), .on_perm(nl_on_perm), .ps_ok(nl_ps_ok),
    .not_u_low(nl_not_u_low), .fault_latched(nl_latched),
    .first_fault(nl_first), .settle_cnt(nl_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(logic [1:0] st, logic [NF-1:0] fl, int ff, int cnt);
    exp_t e;
    e.st = st; e.fl = fl; e.ff = ff; e.cnt = cnt;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    fault_in = '0; fault_mask = '0; upstream_ok = 1'b0; ps_act = 1'b0; u_low = 1'b0; ack = 1'b0;
    nl_fault_in = '0; nl_mask = '0; nl_up = 1'b0; nl_ps = 1'b0; nl_u_low = 1'b0; nl_ack = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (state !== ST_READY) begin failures++; $display("FAIL reset_state got %0d want %0d", state, ST_READY); end
    checks++; if (not_alarm !== 1'b1) begin failures++; $display("FAIL reset_not_alarm got %b want 1", not_alarm); end
    checks++; if (on_perm !== 1'b1) begin failures++; $display("FAIL reset_on_perm got %b want 1", on_perm); end
    checks++; if (ps_ok !== 1'b0) begin failures++; $display("FAIL reset_ps_ok got %b want 0", ps_ok); end
    checks++; if (not_u_low !== 1'b1) begin failures++; $display("FAIL reset_not_u_low got %b want 1", not_u_low); end
    checks++; if (fault_latched !== 4'b0000) begin failures++; $display("FAIL reset_latched got %b want 0000", fault_latched); end
    checks++; if (first_fault !== 2'd0) begin failures++; $display("FAIL reset_first_fault got %0d want 0", first_fault); end
    checks++; if (settle_cnt !== 4'd0) begin failures++; $display("FAIL reset_settle_cnt got %0d want 0", settle_cnt); end
  endtask

  task automatic test_settle();
    exp_t e;
    logic [11:0] obs, want;
    upstream_ok = 1'b1; ps_act = 1'b1;
    for (int j = 0; j <= 8; j++) push((j < 8) ? ST_SETTLE : ST_OK, 4'b0000, 0, j);
    for (int j = 0; j <= 8; j++) begin
      tick();
      e = sb.pop_front();
      want = {e.st, e.fl, (e.ff < 0) ? 2'b00 : 2'(e.ff), (e.cnt < 0) ? 4'b0 : 4'(e.cnt)};
      obs  = {state, fault_latched, (e.ff < 0) ? 2'b00 : first_fault, (e.cnt < 0) ? 4'b0 : settle_cnt};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL settle step %0d: got st/fl/ff/cnt=%h want %h", j, obs, want); end
    end
    checks++; if (ps_ok !== 1'b1) begin failures++; $display("FAIL settle_ps_ok got %b want 1", ps_ok); end
    u_low = 1'b1;
    #1;
    checks++; if (not_u_low !== 1'b0) begin failures++; $display("FAIL u_low_comb got %b want 0", not_u_low); end
    u_low = 1'b0;
    #1;
    checks++; if (not_u_low !== 1'b1) begin failures++; $display("FAIL u_low_release got %b want 1", not_u_low); end
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [11:0] obs, want;
    // two-cycle glitch then a three-cycle fault on channel 1
    for (int j = 0; j < 3; j++) push(ST_OK, 4'b0000, -1, -1);
    for (int j = 0; j < 3; j++) push(ST_OK, 4'b0000, -1, -1);
    push(ST_TRIP, 4'b0010, 1, -1);
    for (int j = 0; j < 7; j++) begin
      fault_in = (j == 0 || j == 1 || j >= 3) ? 4'b0010 : 4'b0000;
      tick();
      e = sb.pop_front();
      want = {e.st, e.fl, (e.ff < 0) ? 2'b00 : 2'(e.ff), (e.cnt < 0) ? 4'b0 : 4'(e.cnt)};
      obs  = {state, fault_latched, (e.ff < 0) ? 2'b00 : first_fault, (e.cnt < 0) ? 4'b0 : settle_cnt};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL glitch step %0d: got st/fl/ff/cnt=%h want %h", j, obs, want); end
    end
    checks++; if (not_alarm !== 1'b0) begin failures++; $display("FAIL trip_not_alarm got %b want 0", not_alarm); end
    checks++; if (on_perm !== 1'b0) begin failures++; $display("FAIL trip_on_perm got %b want 0", on_perm); end
    checks++; if (ps_ok !== 1'b0) begin failures++; $display("FAIL trip_ps_ok got %b want 0", ps_ok); end
  endtask

  task automatic test_latch_ack();
    exp_t e;
    logic [11:0] obs, want;
    logic [3:0] f_seq [4] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic       a_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    push(ST_TRIP, 4'b0010, 1, -1);
    push(ST_TRIP, 4'b0010, 1, -1);
    push(ST_TRIP, 4'b0010, 1, -1);
    push(ST_READY, 4'b0000, -1, 0);
    for (int j = 0; j < 4; j++) begin
      fault_in = f_seq[j];
      ack = a_seq[j];
      tick();
      e = sb.pop_front();
      want = {e.st, e.fl, (e.ff < 0) ? 2'b00 : 2'(e.ff), (e.cnt < 0) ? 4'b0 : 4'(e.cnt)};
      obs  = {state, fault_latched, (e.ff < 0) ? 2'b00 : first_fault, (e.cnt < 0) ? 4'b0 : settle_cnt};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL latch_ack step %0d: got st/fl/ff/cnt=%h want %h", j, obs, want); end
    end
    ack = 1'b0;
    checks++; if (not_alarm !== 1'b1) begin failures++; $display("FAIL ack_not_alarm got %b want 1", not_alarm); end
    checks++; if (on_perm !== 1'b1) begin failures++; $display("FAIL ack_on_perm got %b want 1", on_perm); end
    upstream_ok = 1'b0; ps_act = 1'b0;
    tick();
  endtask

  task automatic test_priority_mask();
    exp_t e;
    logic [11:0] obs, want;
    logic [3:0] f_seq [13] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000,
                               4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 4'b0000};
    logic [3:0] m_seq [13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0000};
    logic       a_seq [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int j = 0; j < 3; j++) push(ST_READY, 4'b0000, -1, -1);
    push(ST_TRIP, 4'b0101, 0, -1);
    push(ST_TRIP, 4'b0101, 0, -1);
    push(ST_READY, 4'b0000, -1, -1);
    for (int j = 0; j < 3; j++) push(ST_READY, 4'b0000, -1, -1);
    push(ST_TRIP, 4'b0100, 2, -1);
    push(ST_TRIP, 4'b0100, 2, -1);
    // widening the mask after the fault must not clear the latched bit
    push(ST_TRIP, 4'b0100, 2, -1);
    push(ST_READY, 4'b0000, -1, -1);
    for (int j = 0; j < 13; j++) begin
      fault_in = f_seq[j];
      fault_mask = m_seq[j];
      ack = a_seq[j];
      tick();
      e = sb.pop_front();
      want = {e.st, e.fl, (e.ff < 0) ? 2'b00 : 2'(e.ff), (e.cnt < 0) ? 4'b0 : 4'(e.cnt)};
      obs  = {state, fault_latched, (e.ff < 0) ? 2'b00 : first_fault, (e.cnt < 0) ? 4'b0 : settle_cnt};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL prio_mask step %0d: got st/fl/ff/cnt=%h want %h", j, obs, want); end
    end
    ack = 1'b0;
    fault_mask = '0;
  endtask

  task automatic test_settle_abort();
    exp_t e;
    logic [11:0] obs, want;
    logic ps_seq [21];
    for (int j = 0; j < 21; j++) ps_seq[j] = 1'b1;
    ps_seq[6] = 1'b0;
    ps_seq[16] = 1'b0;
    for (int j = 0; j <= 5; j++) push(ST_SETTLE, 4'b0000, -1, j);
    push(ST_READY, 4'b0000, -1, -1);
    for (int j = 0; j <= 8; j++) push((j < 8) ? ST_SETTLE : ST_OK, 4'b0000, -1, j);
    push(ST_READY, 4'b0000, -1, -1);
    for (int j = 0; j <= 3; j++) push(ST_SETTLE, 4'b0000, -1, j);
    upstream_ok = 1'b1;
    for (int j = 0; j < 21; j++) begin
      ps_act = ps_seq[j];
      tick();
      e = sb.pop_front();
      want = {e.st, e.fl, (e.ff < 0) ? 2'b00 : 2'(e.ff), (e.cnt < 0) ? 4'b0 : 4'(e.cnt)};
      obs  = {state, fault_latched, (e.ff < 0) ? 2'b00 : first_fault, (e.cnt < 0) ? 4'b0 : settle_cnt};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL settle_abort step %0d: got st/fl/ff/cnt=%h want %h", j, obs, want); end
    end
    reset = 1'b1;
    u_low = 1'b1;
    tick();
    checks++; if (state !== ST_READY) begin failures++; $display("FAIL midreset_state got %0d want %0d", state, ST_READY); end
    checks++; if (settle_cnt !== 4'd0) begin failures++; $display("FAIL midreset_cnt got %0d want 0", settle_cnt); end
    checks++; if (ps_ok !== 1'b0) begin failures++; $display("FAIL midreset_ps_ok got %b want 0", ps_ok); end
    checks++; if (on_perm !== 1'b1) begin failures++; $display("FAIL midreset_on_perm got %b want 1", on_perm); end
    checks++; if (not_alarm !== 1'b1) begin failures++; $display("FAIL midreset_not_alarm got %b want 1", not_alarm); end
    checks++; if (not_u_low !== 1'b1) begin failures++; $display("FAIL midreset_not_u_low got %b want 1", not_u_low); end
    checks++; if (first_fault !== 2'd0) begin failures++; $display("FAIL midreset_first_fault got %0d want 0", first_fault); end
    checks++; if (fault_latched !== 4'b0000) begin failures++; $display("FAIL midreset_latched got %b want 0000", fault_latched); end
    reset = 1'b0;
    u_low = 1'b0;
    upstream_ok = 1'b0; ps_act = 1'b0;
    tick();
  endtask

  task automatic test_non_latching();
    exp_t e;
    logic [11:0] obs, want;
    for (int j = 0; j < 3; j++) push(ST_READY, 4'b0000, -1, 0);
    push(ST_TRIP, 4'b1000, 3, 0);
    push(ST_READY, 4'b0000, -1, 0);
    for (int j = 0; j < 5; j++) begin
      nl_fault_in = (j < 3) ? 4'b1000 : 4'b0000;
      tick();
      e = sb.pop_front();
      want = {e.st, e.fl, (e.ff < 0) ? 2'b00 : 2'(e.ff), (e.cnt < 0) ? 4'b0 : 4'(e.cnt)};
      obs  = {nl_state, nl_latched, (e.ff < 0) ? 2'b00 : nl_first, (e.cnt < 0) ? 4'b0 : nl_cnt};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL non_latching step %0d: got st/fl/ff/cnt=%h want %h", j, obs, want); end
      if (j == 3) begin
        checks++; if (nl_on_perm !== 1'b0) begin failures++; $display("FAIL nl_trip_on_perm got %b want 0", nl_on_perm); end
        checks++; if (nl_not_alarm !== 1'b0) begin failures++; $display("FAIL nl_trip_not_alarm got %b want 0", nl_not_alarm); end
      end
    end
    checks++; if (nl_on_perm !== 1'b1) begin failures++; $display("FAIL nl_clear_on_perm got %b want 1", nl_on_perm); end
    checks++; if ({nl_ps_ok, nl_not_u_low} !== 2'b01) begin failures++; $display("FAIL nl_idle_outputs got %b want 01", {nl_ps_ok, nl_not_u_low}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_settle();
    test_glitch();
    test_latch_ack();
    test_priority_mask();
    test_settle_abort();
    test_non_latching();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
